// File: rtl/timer_bank.sv
// timer_bank: bank of independent down-counting timers with byte-wide CPU register access.
// Each channel: reload, live count with read snapshot, control (EN/PERIODIC/IE) and W1C pending status.
module timer_bank #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [5:0]          addr,
  input  logic                wr,
  input  logic [7:0]          wdata,
  output logic [7:0]          rdata,
  output logic [CHANNELS-1:0] irq_vec,
  output logic                irq
);
  logic [3:0] w_reg;
  logic [4:0] w_bit;
  logic [7:0] w_rbytes [CHANNELS];
  logic [7:0] w_rd;
  assign w_reg = addr[3:0];
  assign w_bit = {addr[1:0], 3'b000};
  genvar c;
  for (c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] r_reload, r_count, r_snap;
    logic             r_en, r_per, r_ie, r_pend;
    logic             w_sel, w_wr_rel, w_wr_ctl, w_wr_sts, w_rd_snap;
    logic             w_rise, w_tick, w_expire, w_per;
    logic [31:0]      w_rel_ext, w_rel_new, w_cnt_ext, w_snap_ext;
    logic [7:0]       w_rbyte;
    assign w_sel      = addr[5:4] == 2'(c);
    assign w_wr_rel   = wr & w_sel & (w_reg < 4'd4);
    assign w_wr_ctl   = wr & w_sel & (w_reg == 4'd8);
    assign w_wr_sts   = wr & w_sel & (w_reg == 4'd9);
    assign w_rd_snap  = ~wr & w_sel & (w_reg == 4'd4);
    assign w_rel_ext  = 32'(r_reload);
    assign w_cnt_ext  = 32'(r_count);
    assign w_snap_ext = 32'(r_snap);
    // A control write that clears EN freezes the count on that very edge.
    assign w_rise   = w_wr_ctl & wdata[0] & ~r_en;
    assign w_tick   = r_en & (~w_wr_ctl | wdata[0]);
    assign w_expire = w_tick & (r_count == '0);
    assign w_per    = w_wr_ctl ? wdata[1] : r_per;
    always_comb begin
      w_rel_new = w_rel_ext;
      w_rel_new[w_bit +: 8] = wdata;
    end
    assign w_rbyte = (w_reg < 4'd4)  ? w_rel_ext[w_bit +: 8] :
                     (w_reg == 4'd4) ? w_cnt_ext[7:0] :
                     (w_reg < 4'd8)  ? w_snap_ext[w_bit +: 8] :
                     (w_reg == 4'd8) ? {5'b0, r_ie, r_per, r_en} :
                     (w_reg == 4'd9) ? {7'b0, r_pend} : 8'h00;
    assign w_rbytes[c] = w_sel ? w_rbyte : 8'h00;
    assign irq_vec[c]  = r_pend & r_ie;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_reload <= '0;
        r_count  <= '0;
        r_snap   <= '0;
        r_en     <= 1'b0;
        r_per    <= 1'b0;
        r_ie     <= 1'b0;
        r_pend   <= 1'b0;
      end else begin
        if (w_wr_rel) r_reload <= w_rel_new[WIDTH-1:0];
        if (w_rd_snap) r_snap <= r_count;
        if (w_rise) r_count <= r_reload;
        else if (w_tick) r_count <= (r_count != '0) ? r_count - 1'b1 : (w_per ? r_reload : r_count);
        r_en <= (w_wr_ctl ? wdata[0] : r_en) & ~(w_expire & ~w_per);
        if (w_wr_ctl) begin
          r_per <= wdata[1];
          r_ie  <= wdata[2];
        end
        r_pend <= w_expire | (r_pend & ~(w_wr_sts & wdata[0]));
      end
    end
  end
  always_comb begin
    w_rd = 8'h00;
    for (int i = 0; i < CHANNELS; i++) w_rd = w_rd | w_rbytes[i];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdata <= 8'h00;
    else if (!wr) rdata <= w_rd;
  end
  assign irq = |irq_vec;
endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: random and directed stimulus checked against a cycle-level reference model of the timer bank.
module tb_timer_bank;
  localparam int CH = 2;
  localparam int W  = 24;
  localparam longint unsigned MASK = (64'd1 << W) - 1;
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [5:0]    addr = '0;
  logic          wr = 1'b0;
  logic [7:0]    wdata = '0;
  logic [7:0]    rdata;
  logic [CH-1:0] irq_vec;
  logic          irq;
  timer_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .wr(wr), .wdata(wdata),
    .rdata(rdata), .irq_vec(irq_vec), .irq(irq)
  );
  always #5 clk = ~clk;
  int n_vec = 0;
  int n_err = 0;
  longint unsigned m_rel [CH], m_cnt [CH], m_snap [CH];
  bit m_en [CH], m_per [CH], m_ie [CH], m_pend [CH];
  logic [7:0] m_rd;
  logic [7:0] b0, b1, b2;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [7:0] byte_of(input longint unsigned v, input int b);
    return 8'((v >> (8 * b)) & 64'hFF);
  endfunction
  function automatic logic [CH-1:0] m_irq();
    logic [CH-1:0] v;
    for (int i = 0; i < CH; i++) v[i] = m_pend[i] & m_ie[i];
    return v;
  endfunction
  task automatic m_reset();
    for (int i = 0; i < CH; i++) begin
      m_rel[i] = 0; m_cnt[i] = 0; m_snap[i] = 0;
      m_en[i] = 0; m_per[i] = 0; m_ie[i] = 0; m_pend[i] = 0;
    end
    m_rd = 0;
  endtask
  // One clock edge of the register-level behaviour, starting from the pre-edge state.
  task automatic m_step(input logic [5:0] a, input logic w, input logic [7:0] d);
    int ch, r;
    bit hit, wctl, ticking, per_now;
    ch = int'(a[5:4]);
    r  = int'(a[3:0]);
    if (!w) begin
      m_rd = 0;
      if (ch < CH) begin
        if (r < 4) m_rd = byte_of(m_rel[ch], r);
        else if (r == 4) m_rd = byte_of(m_cnt[ch], 0);
        else if (r < 8) m_rd = byte_of(m_snap[ch], r - 4);
        else if (r == 8) m_rd = {5'b0, m_ie[ch], m_per[ch], m_en[ch]};
        else if (r == 9) m_rd = {7'b0, m_pend[ch]};
      end
    end
    for (int i = 0; i < CH; i++) begin
      hit  = w && ch == i;
      wctl = hit && r == 8;
      if (!w && ch == i && r == 4) m_snap[i] = m_cnt[i];
      if (hit && r == 9 && d[0]) m_pend[i] = 0;
      if (wctl && d[0] && !m_en[i]) begin
        m_cnt[i] = m_rel[i];
        m_en[i]  = 1;
      end else begin
        ticking = m_en[i] && !(wctl && !d[0]);
        per_now = wctl ? d[1] : m_per[i];
        if (wctl) m_en[i] = d[0];
        if (ticking) begin
          if (m_cnt[i] != 0) m_cnt[i] = m_cnt[i] - 1;
          else begin
            m_pend[i] = 1;
            if (per_now) m_cnt[i] = m_rel[i];
            else m_en[i] = 0;
          end
        end
      end
      if (wctl) begin
        m_per[i] = d[1];
        m_ie[i]  = d[2];
      end
      if (hit && r < 4)
        m_rel[i] = ((m_rel[i] & ~(64'hFF << (8 * r))) | (longint'(d) << (8 * r))) & MASK;
    end
  endtask
  task automatic cyc(input logic [5:0] a, input logic w, input logic [7:0] d);
    addr = a; wr = w; wdata = d;
    m_step(a, w, d);
    @(posedge clk); #1;
    check("rdata", rdata, m_rd);
    check("irq_vec", {irq, irq_vec}, {|m_irq(), m_irq()});
  endtask
  task automatic wreg(input int ch, input int r, input logic [7:0] d);
    cyc({2'(ch), 4'(r)}, 1'b1, d);
  endtask
  task automatic rreg(input int ch, input int r);
    cyc({2'(ch), 4'(r)}, 1'b0, 8'h00);
  endtask
  initial begin
    int r;
    logic [7:0] d;
    m_reset();
    #3;
    check("reset_rdata", rdata, 8'h00);
    check("reset_irq", {irq, irq_vec}, '0);
    #9 reset_n = 1'b1;
    // periodic reload=4: pending five edges after the enabling write
    wreg(0, 0, 8'h04);
    wreg(0, 8, 8'h07);
    for (int k = 1; k <= 5; k++) begin
      rreg(0, 8);
      if (k == 4) check("p_irq_early", irq, 1'b0);
      if (k == 5) check("p_irq_5", irq, 1'b1);
    end
    wreg(0, 9, 8'h01);
    for (int k = 0; k < 11; k++) rreg(0, 9);
    wreg(0, 8, 8'h00);
    wreg(0, 9, 8'h01);
    // one-shot on channel 1
    wreg(1, 0, 8'h02);
    wreg(1, 8, 8'h05);
    for (int k = 0; k < 4; k++) rreg(1, 4);
    rreg(1, 8);
    check("os_ctl", rdata, 8'h04);
    rreg(1, 4);
    check("os_cnt", rdata, 8'h00);
    check("os_irq", irq_vec[1], 1'b1);
    wreg(1, 9, 8'h01);
    for (int k = 0; k < 8; k++) rreg(1, 9);
    check("os_no_rearm", irq, 1'b0);
    // reload=0 periodic with W1C every cycle: set wins
    wreg(0, 0, 8'h00);
    wreg(0, 8, 8'h07);
    for (int k = 0; k < 10; k++) begin
      wreg(0, 9, 8'h01);
      check("w1c_set_wins", irq_vec[0], 1'b1);
    end
    wreg(0, 8, 8'h00);
    wreg(0, 9, 8'h01);
    // upper reload byte beyond WIDTH, snapshot consistency
    wreg(0, 3, 8'hFF);
    rreg(0, 3);
    check("rel_b3", rdata, 8'h00);
    wreg(0, 0, 8'h56);
    wreg(0, 1, 8'h34);
    wreg(0, 2, 8'h12);
    wreg(0, 8, 8'h01);
    for (int k = 0; k < 5; k++) rreg(0, 8);
    rreg(0, 4); b0 = rdata;
    rreg(0, 5); b1 = rdata;
    rreg(0, 6); b2 = rdata;
    check("snap_b1", b1, 8'h34);
    check("snap_b2", b2, 8'h12);
    check("snap_b0", b0 > 8'h40 && b0 < 8'h56, 1'b1);
    rreg(0, 7);
    check("snap_b3", rdata, 8'h00);
    wreg(0, 8, 8'h00);
    // channel index beyond CHANNELS
    rreg(3, 0);
    check("bad_ch_rd", rdata, 8'h00);
    wreg(3, 0, 8'hAA);
    wreg(2, 8, 8'h07);
    rreg(3, 8);
    check("bad_ch_ctl", rdata, 8'h00);
    // random traffic
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 15);
      d = 8'($urandom);
      if (r >= 1 && r <= 3 && $urandom_range(0, 7) != 0) d = 8'h00;
      if (r == 0) d = d & 8'h0F;
      cyc({2'($urandom_range(0, 3)), 4'(r)}, 1'($urandom_range(0, 2) == 0), d);
    end
    // reset mid-count with pending set
    wreg(0, 0, 8'h01);
    wreg(0, 1, 8'h00);
    wreg(0, 2, 8'h00);
    wreg(1, 8, 8'h00);
    wreg(0, 8, 8'h07);
    for (int k = 0; k < 3; k++) rreg(0, 8);
    check("pre_rst_irq", irq, 1'b1);
    #2 reset_n = 1'b0;
    m_reset();
    #1;
    check("rst_irq", {irq, irq_vec}, '0);
    check("rst_rdata", rdata, 8'h00);
    #3 reset_n = 1'b1;
    for (int ch = 0; ch < CH; ch++)
      for (int rg = 0; rg < 10; rg++) begin
        rreg(ch, rg);
        check("post_rst_reg", rdata, 8'h00);
      end
    for (int k = 0; k < 5; k++) rreg(0, 9);
    check("post_rst_idle", irq, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
